tick_stopwatch: RTL and testbench
=================================

// Module: tick_stopwatch
// PURPOSE
//  Consumes the divided clock produced by the clock divider (nominally 1 Hz) as a plain data
//  signal in the clk domain, detects its rising edges and counts them as elapsed seconds.
//  The count is a four-digit BCD MM:SS stopwatch with start/stop and clear controls.
//  Its outputs feed the display driver.
// PARAMETERS
//  SYNC_STAGES  2   flops sampling div_in before edge detect (>=1)
//  MIN_LIMIT    59  highest minute value; legal range 1..99; MM:SS wraps after MIN_LIMIT:59
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst_n       in   1  synchronous reset, active-low
//  div_in      in   1  divided clock from the clock divider; rising edge = one second
//  start_stop  in   1  one-cycle pulse; toggles run/pause
//  clear       in   1  one-cycle pulse; zero the count and stop
//  sec_ones    out  4  BCD seconds units, 0..9
//  sec_tens    out  4  BCD seconds tens, 0..5
//  min_ones    out  4  BCD minutes units, 0..9
//  min_tens    out  4  BCD minutes tens, 0..9
//  running     out  1  high in RUN state
//  tick_out    out  1  one-cycle pulse per div_in rising edge, in every state
//  rollover    out  1  one-cycle pulse when MIN_LIMIT:59 wraps to 00:00
// BEHAVIOUR
//  - Reset (rst_n low at a posedge):
//    - all digits 0, running/tick_out/rollover 0, state IDLE.
//    - sync and history flops load 1, so div_in already high at reset release gives no tick.
//  - Edge detect:
//    - div_in passes through SYNC_STAGES flops; an edge is last-stage=1 with history=0.
//    - tick_out is registered: if div_in is low at edge k-1 and high at edge k, tick_out is
//      high for the cycle after edge k+SYNC_STAGES-1.
//    - Each rising edge yields exactly one tick_out; there is no debounce.
//  - FSM, using the current state; clear has priority over everything:
//    - IDLE --start_stop--> RUN
//    - RUN --start_stop--> PAUSE
//    - PAUSE --start_stop--> RUN
//    - any state --clear--> IDLE, digits 0
//    - clear and start_stop in the same cycle: clear wins, state IDLE.
//  - Counting: at the posedge where tick_out=1 and state is RUN, MM:SS increments by one.
//    - Digit update is visible 1 cycle after the tick_out cycle.
//    - Ticks in IDLE or PAUSE are discarded; none are buffered.
//    - Tick and start_stop together in RUN: the tick is counted, then state is PAUSE.
//    - Tick and start_stop together in PAUSE: the tick is not counted.
//    - Tick and clear together: clear wins, count is 0.
//  - BCD carry chain:
//    - sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into minutes.
//    - Minutes count 0..MIN_LIMIT in BCD (min_ones 9->0 carries into min_tens).
//    - At MIN_LIMIT:59 a counted tick gives 00:00 and rollover high for one cycle, registered
//      alongside the digits; state stays RUN.
//  - running = (state==RUN), registered.
//  - Digits never hold a non-BCD value; out-of-range MIN_LIMIT is a configuration error.
//  - Reset mid-operation wins over all inputs on that edge.
// TESTING
//  1. Reset with div_in held high, then div_in held high for 20 cycles -> tick_out stays 0,
//     digits 00:00, running 0.
//  2. div_in period 8 clk, start_stop at cycle 3, 10 rising edges -> tick_out pulses 10x;
//     digits 00:10; running 1.
//  3. Run 65 edges -> 01:05.
//     MIN_LIMIT=1: run 119 edges -> 01:59; next edge -> 00:00 and a single-cycle rollover.
//  4. RUN at 00:07; start_stop; 5 more edges -> stays 00:07, tick_out still pulses;
//     start_stop; 2 edges -> 00:09.
//  5. clear and start_stop in the same cycle while in RUN at 00:30 -> 00:00, running 0;
//     then a tick and start_stop in the same cycle while in RUN -> that tick counts,
//     state becomes PAUSE.
//  6. rst_n low for 1 cycle at 02:13 while running -> next cycle 00:00, running 0,
//     no tick_out if div_in is high.

Source files
------------

// File: rtl/tick_stopwatch.sv
// MM:SS BCD stopwatch counting rising edges of the divided clock as seconds.
// Start/stop toggles run/pause; clear zeroes the count and returns to idle.
module tick_stopwatch #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LIMIT   = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       div_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       tick_out,
    output logic       rollover
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } stateT;

    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

    stateT                  state;
    logic [SYNC_STAGES-1:0] syncQ;
    logic [SYNC_STAGES:0]   chain;
    logic                   countEn;

    // The top of the chain doubles as the edge-detect history, so the edge is
    // judged on the flop inputs and tick_out lands SYNC_STAGES cycles after div_in.
    assign chain   = {syncQ, div_in};
    assign countEn = tick_out && (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sync/history reset to 1 so a div_in already high at release is not an edge.
            syncQ    <= '1;
            tick_out <= 1'b0;
            state    <= IDLE;
            running  <= 1'b0;
            rollover <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else begin
            syncQ    <= chain[SYNC_STAGES-1:0];
            tick_out <= chain[SYNC_STAGES-1] & ~chain[SYNC_STAGES];
            rollover <= 1'b0;

            if (clear) begin
                state    <= IDLE;
                running  <= 1'b0;
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                min_ones <= 4'd0;
                min_tens <= 4'd0;
            end else begin
                if (countEn) begin
                    if (sec_ones != 4'd9) begin
                        sec_ones <= sec_ones + 4'd1;
                    end else begin
                        sec_ones <= 4'd0;
                        if (sec_tens != 4'd5) begin
                            sec_tens <= sec_tens + 4'd1;
                        end else begin
                            sec_tens <= 4'd0;
                            if (min_tens == LIM_TENS && min_ones == LIM_ONES) begin
                                min_ones <= 4'd0;
                                min_tens <= 4'd0;
                                rollover <= 1'b1;
                            end else if (min_ones != 4'd9) begin
                                min_ones <= min_ones + 4'd1;
                            end else begin
                                min_ones <= 4'd0;
                                min_tens <= min_tens + 4'd1;
                            end
                        end
                    end
                end

                // A tick coinciding with start_stop in RUN was counted above before pausing.
                if (start_stop) begin
                    case (state)
                        RUN: begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                        default: begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Scoreboarded bench for tick_stopwatch: default instance (MIN_LIMIT=59) plus a
// MIN_LIMIT=1 instance for the rollover boundary.
module tb_tick_stopwatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, divA, ssA, clrA, divB, ssB, clrB;
    logic [3:0] aSo, aSt, aMo, aMt, bSo, bSt, bMo, bMt;
    logic aRun, aTick, aRoll, bRun, bTick, bRoll;

    tick_stopwatch dutA (
        .clk(clk), .rst_n(rst_n), .div_in(divA), .start_stop(ssA), .clear(clrA),
        .sec_ones(aSo), .sec_tens(aSt), .min_ones(aMo), .min_tens(aMt),
        .running(aRun), .tick_out(aTick), .rollover(aRoll)
    );

    tick_stopwatch #(.SYNC_STAGES(2), .MIN_LIMIT(1)) dutB (
        .clk(clk), .rst_n(rst_n), .div_in(divB), .start_stop(ssB), .clear(clrB),
        .sec_ones(bSo), .sec_tens(bSt), .min_ones(bMo), .min_tens(bMt),
        .running(bRun), .tick_out(bTick), .rollover(bRoll)
    );

    typedef struct {
        logic [15:0] digits;
        logic        roll;
    } expT;

    expT sbQ[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  ticksA = 0;
    int  rollB = 0;
    int  modelSec = 0;
    bit  modelRun = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Monitor: a tick_out cycle means the digits settle one cycle later.
    initial begin
        bit  prevTick;
        expT e;
        prevTick = 1'b0;
        forever begin
            @(negedge clk);
            if (prevTick) begin
                if (sbQ.size() == 0) begin
                    check("tick without expectation", 32'(sbQ.size()), 32'd1);
                end else begin
                    e = sbQ.pop_front();
                    check("tick digits", {16'd0, aMt, aMo, aSt, aSo}, {16'd0, e.digits});
                    check("tick rollover", {31'd0, aRoll}, {31'd0, e.roll});
                end
            end
            prevTick = aTick;
            if (aTick) ticksA++;
            if (bRoll) rollB++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseSs(input bit sel);
        @(negedge clk);
        if (sel) ssB = 1'b1;
        else begin
            ssA = 1'b1;
            modelRun = !modelRun;
        end
        @(negedge clk);
        ssA = 1'b0;
        ssB = 1'b0;
    endtask

    task automatic clearA();
        @(negedge clk);
        clrA = 1'b1;
        @(negedge clk);
        clrA = 1'b0;
        modelSec = 0;
        modelRun = 1'b0;
    endtask

    // One div_in period of 8 clocks: high 4, low 4 (unless left high).
    task automatic edgeDiv(input bit sel, input bit leaveHigh);
        expT e;
        @(negedge clk);
        if (sel) divB = 1'b1;
        else begin
            divA = 1'b1;
            e.roll = 1'b0;
            if (modelRun) begin
                modelSec++;
                if (modelSec == 3600) begin
                    modelSec = 0;
                    e.roll = 1'b1;
                end
            end
            e.digits = bcd(modelSec / 60, modelSec % 60);
            sbQ.push_back(e);
        end
        cyc(4);
        if (!leaveHigh) begin
            divA = 1'b0;
            divB = 1'b0;
        end
        cyc(3);
    endtask

    task automatic checkA(input string name, input int mm, input int ss, input bit run);
        check({name, " digits"}, {16'd0, aMt, aMo, aSt, aSo}, {16'd0, bcd(mm, ss)});
        check({name, " running"}, {31'd0, aRun}, {31'd0, run});
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        divA = 1'b1; divB = 1'b1;
        ssA = 1'b0; ssB = 1'b0; clrA = 1'b0; clrB = 1'b0;

        // 1: reset with div_in high, held high afterwards
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        check("reset ticks", 32'(ticksA), 32'd0);
        checkA("reset", 0, 0, 1'b0);
        check("reset rollover", {31'd0, aRoll}, 32'd0);
        divA = 1'b0; divB = 1'b0;

        // 2: start then 10 edges
        cyc(2);
        pulseSs(1'b0);
        t0 = ticksA;
        repeat (10) edgeDiv(1'b0, 1'b0);
        check("run10 ticks", 32'(ticksA - t0), 32'd10);
        checkA("run10", 0, 10, 1'b1);

        // 3: 65 edges from zero
        clearA();
        pulseSs(1'b0);
        repeat (65) edgeDiv(1'b0, 1'b0);
        checkA("run65", 1, 5, 1'b1);

        // 4: pause discards ticks
        clearA();
        pulseSs(1'b0);
        repeat (7) edgeDiv(1'b0, 1'b0);
        checkA("pre-pause", 0, 7, 1'b1);
        pulseSs(1'b0);
        t0 = ticksA;
        repeat (5) edgeDiv(1'b0, 1'b0);
        check("paused ticks", 32'(ticksA - t0), 32'd5);
        checkA("paused", 0, 7, 1'b0);
        pulseSs(1'b0);
        repeat (2) edgeDiv(1'b0, 1'b0);
        checkA("resumed", 0, 9, 1'b1);

        // 5: clear+start_stop together, then tick+start_stop together
        clearA();
        pulseSs(1'b0);
        repeat (30) edgeDiv(1'b0, 1'b0);
        checkA("at 00:30", 0, 30, 1'b1);
        @(negedge clk);
        clrA = 1'b1; ssA = 1'b1;
        @(negedge clk);
        clrA = 1'b0; ssA = 1'b0;
        modelSec = 0; modelRun = 1'b0;
        checkA("clear wins", 0, 0, 1'b0);
        pulseSs(1'b0);
        begin
            expT e;
            @(negedge clk);
            divA = 1'b1;
            modelSec++;
            e.digits = bcd(0, modelSec);
            e.roll = 1'b0;
            sbQ.push_back(e);
            cyc(2);
            check("tick with start_stop", {31'd0, aTick}, 32'd1);
            ssA = 1'b1;
            modelRun = 1'b0;
            @(negedge clk);
            ssA = 1'b0;
            cyc(2);
            divA = 1'b0;
            cyc(4);
        end
        checkA("tick then pause", 0, 1, 1'b0);

        // 6: reset mid-run at 02:13 with div_in high
        clearA();
        pulseSs(1'b0);
        repeat (132) edgeDiv(1'b0, 1'b0);
        edgeDiv(1'b0, 1'b1);
        checkA("at 02:13", 2, 13, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelSec = 0; modelRun = 1'b0;
        checkA("mid reset", 0, 0, 1'b0);
        t0 = ticksA;
        cyc(10);
        check("mid reset ticks", 32'(ticksA - t0), 32'd0);
        divA = 1'b0;
        cyc(4);

        // MIN_LIMIT=1 rollover boundary
        pulseSs(1'b1);
        repeat (119) edgeDiv(1'b1, 1'b0);
        check("lim1 digits 01:59", {16'd0, bMt, bMo, bSt, bSo}, {16'd0, bcd(1, 59)});
        check("lim1 no rollover yet", 32'(rollB), 32'd0);
        edgeDiv(1'b1, 1'b0);
        check("lim1 wrap digits", {16'd0, bMt, bMo, bSt, bSo}, {16'd0, bcd(0, 0)});
        check("lim1 rollover cycles", 32'(rollB), 32'd1);
        check("lim1 still running", {31'd0, bRun}, 32'd1);

        check("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
